dbg_mem_reader: RTL and testbench
=================================

# dbg_mem_reader

Debug memory readback engine for the crv32 SoC: the read-side counterpart of the debug memory write path used to preload program RAM while the CPU is held in reset. On a start pulse it issues word reads on the SoC debug memory port (`dbg_mem_op`, `dbg_wren`, `dbg_adr`, `dbg_di`) from a base address for a given word count. It streams each word out little-endian as bytes on a valid/ready byte interface that feeds the UART transmitter, so host tools can verify loaded images.

## Interface
Parameters:
- `CNT_W`, 16, width of the word-count input and internal remaining-word counter.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_adr`  in  32  first word address; bits [1:0] ignored (treated as 0).
- `count`  in  CNT_W  number of 32-bit words to read; 0 is legal.
- `abort`  in  1  cancel the transfer; takes priority over all other inputs.
- `busy`  out  1  high from the cycle after an accepted start until done/abort.
- `done`  out  1  one-cycle pulse after the last byte is accepted.
- `dbg_mem_op`  out  1  debug port owns memory while high.
- `dbg_wren`  out  4  byte write enables; constant 4'h0 (read-only master).
- `dbg_adr`  out  32  word-aligned read address.
- `dbg_di`  in  32  memory read data; valid one cycle after the address is presented.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  sink accepts the byte when `tx_valid & tx_ready`.

## Operation
- States: IDLE, REQ, WAIT, SEND, DONE.
- IDLE: `busy=0`. On `start`, latch `{base_adr[31:2],2'b00}` into the address register and `count` into the remaining counter.
  - If `count==0`, go to DONE.
  - Otherwise go to REQ.
- REQ: `dbg_mem_op=1`, `dbg_adr` = address register. Always go to WAIT.
- WAIT: `dbg_mem_op=1` with the address held. At the end of the cycle, latch `dbg_di` into a 32-bit shift register, clear the byte index to 0, and go to SEND.
- SEND: `dbg_mem_op=0`, `tx_valid=1`, `tx_data` = shift register [7:0].
  - On handshake, shift right by 8 and increment the byte index.
  - On the handshake with byte index 3:
    - decrement remaining and add 4 to the address (mod 2^32, wraps 0xFFFFFFFC→0x00000000);
    - if remaining was 1, go to DONE, else go to REQ.
- DONE: `done=1`, `busy=0` for exactly one cycle, then IDLE.
- `tx_data` must hold stable while `tx_valid & ~tx_ready`.
- Byte order per word: [7:0], [15:8], [23:16], [31:24].
- `start` outside IDLE is ignored.
- `abort` in any state ≠ IDLE forces IDLE at the next edge. `abort` produces no `done` pulse and drops `tx_valid` and `dbg_mem_op` immediately in that next cycle. `abort` in IDLE has no effect and blocks a simultaneous `start`.
- Remaining counter is CNT_W bits; `count` = 2^CNT_W−1 must complete without overflow.

## Timing
- Reset values: state IDLE; `busy=0`, `done=0`, `dbg_mem_op=0`, `dbg_wren=4'h0`, `dbg_adr=0`, `tx_data=0`, `tx_valid=0`; internal registers cleared.
- `start` at cycle N:
  - N+1: REQ, `busy=1`, `dbg_mem_op=1`.
  - N+2: WAIT.
  - N+3: first `tx_valid`.
- Per word with `tx_ready` held high: 2 cycles (REQ, WAIT) + 4 SEND cycles = 6 cycles.
- `count=1` with `tx_ready=1`: `done` at N+7, `busy` 0 from N+7.
- `count=0`: `done` at N+1; no `dbg_mem_op`, no bytes.
- `busy` is not asserted in DONE.
- Outputs are registered or pure decodes of the state register; no combinational path from `tx_ready` to `tx_valid`.
- Async reset mid-transfer: all outputs return to reset values immediately, with no `done` pulse.

## Test plan
- Memory preloaded 0x20000:000107b7, 0x20004:0007a023; `start`, `base_adr=0x20000`, `count=2`, `tx_ready=1` -> bytes b7 07 01 00 23 a0 07 00, `done` pulse at start+13, `dbg_wren` always 0.
- `count=0` -> `done` the cycle after `start`, `tx_valid` and `dbg_mem_op` never high.
- `base_adr=0x20003`, `count=1` -> `dbg_adr=0x20000`. Alternatively `base_adr=0xFFFFFFFC`, `count=2` -> second read at 0x00000000.
- `tx_ready` toggled 1 cycle on/3 off during `count=3` -> `tx_data` stable while stalled, 12 bytes in order, no drops or duplicates.
- `abort` during the second word's SEND -> IDLE next cycle, `tx_valid=0`, no `done`; a new `start` then reads correctly from its own `base_adr`.
- `n_reset` asserted in WAIT -> all outputs at reset values without waiting for a clock; `start` while `busy` -> ignored and byte count unchanged.

Source files
------------

// File: rtl/dbg_mem_reader.sv
// rtl/dbg_mem_reader.sv - debug memory readback engine streaming words as little-endian bytes
module dbg_mem_reader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [31:0]      base_adr,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             dbg_mem_op,
    output logic [3:0]       dbg_wren,
    output logic [31:0]      dbg_adr,
    input  logic [31:0]      dbg_di,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [31:0]      adr_q, adr_nxt;
    logic [31:0]      shreg_q, shreg_nxt;
    logic [CNT_W-1:0] rem_q, rem_nxt;
    logic [1:0]       idx_q, idx_nxt;

    // Address LSBs are deliberately dropped; reads are always word aligned.
    logic unused_adr_lsb;
    assign unused_adr_lsb = ^base_adr[1:0];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state   <= S_IDLE;
            adr_q   <= '0;
            shreg_q <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
        end else begin
            state   <= state_nxt;
            adr_q   <= adr_nxt;
            shreg_q <= shreg_nxt;
            rem_q   <= rem_nxt;
            idx_q   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        adr_nxt   = adr_q;
        shreg_nxt = shreg_q;
        rem_nxt   = rem_q;
        idx_nxt   = idx_q;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    adr_nxt   = {base_adr[31:2], 2'b00};
                    rem_nxt   = count;
                    state_nxt = (count == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ:  state_nxt = S_WAIT;
            S_WAIT: begin
                shreg_nxt = dbg_di;
                idx_nxt   = 2'd0;
                state_nxt = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    shreg_nxt = {8'h00, shreg_q[31:8]};
                    idx_nxt   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        rem_nxt   = rem_q - CNT_W'(1);
                        adr_nxt   = adr_q + 32'd4;
                        state_nxt = (rem_q == CNT_W'(1)) ? S_DONE : S_REQ;
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        // Abort wins over everything except in IDLE, where it only masks start.
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
        end
    end

    // All outputs are state decodes or register taps: no ready-to-valid path.
    assign busy       = (state == S_REQ) || (state == S_WAIT) || (state == S_SEND);
    assign done       = (state == S_DONE);
    assign dbg_mem_op = (state == S_REQ) || (state == S_WAIT);
    assign dbg_wren   = 4'h0;
    assign dbg_adr    = adr_q;
    assign tx_valid   = (state == S_SEND);
    assign tx_data    = shreg_q[7:0];

endmodule

// File: tb/tb_dbg_mem_reader.sv
// tb/tb_dbg_mem_reader.sv - scoreboard bench for dbg_mem_reader
module tb_dbg_mem_reader;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start;
    logic [31:0] base_adr;
    logic [15:0] count;
    logic        abort;
    logic        busy;
    logic        done;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr;
    logic [31:0] dbg_di = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    always #5 clk = ~clk;

    dbg_mem_reader #(.CNT_W(16)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (start),
        .base_adr   (base_adr),
        .count      (count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .dbg_mem_op (dbg_mem_op),
        .dbg_wren   (dbg_wren),
        .dbg_adr    (dbg_adr),
        .dbg_di     (dbg_di),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] adr_log[$];
    int          ready_mode = 0;
    bit          done_seen, memop_seen, txv_seen;
    bit          prev_stall = 0;
    bit          prev_memop = 0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0002_0000) return 32'h0001_07b7;
        if (a == 32'h0002_0004) return 32'h0007_a023;
        return {~a[15:0], a[15:0]} ^ 32'h1234_8765;
    endfunction

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
    endtask

    // Memory returns data one cycle after the address is presented.
    always @(posedge clk) dbg_di <= mem_word(dbg_adr);

    initial begin
        int cyc;
        cyc = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 4 == 0);
                default: tx_ready = 1'b0;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (n_reset) begin
                if (done) done_seen = 1;
                if (dbg_mem_op) memop_seen = 1;
                if (tx_valid) txv_seen = 1;
                if (dbg_mem_op) check("dbg_wren", {28'h0, dbg_wren}, 32'h0);
                if (dbg_mem_op && !prev_memop) adr_log.push_back(dbg_adr);
                if (prev_stall && tx_valid) check("tx_hold", {24'h0, tx_data}, {24'h0, prev_data});
                if (tx_valid && tx_ready) begin
                    check("byte_expected", {31'h0, exp_q.size() != 0}, 32'h1);
                    if (exp_q.size() != 0) check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                prev_memop = dbg_mem_op;
            end else begin
                prev_stall = 0;
                prev_memop = 0;
            end
        end
    end

    task automatic run_xfer(input logic [31:0] base, input logic [15:0] cnt,
                            input bit extra_start, output int lat);
        int k;
        done_seen  = 0;
        memop_seen = 0;
        txv_seen   = 0;
        adr_log.delete();
        for (int i = 0; i < int'(cnt); i++) push_word(mem_word({base[31:2], 2'b00} + 32'(4 * i)));
        @(posedge clk);
        #1;
        start    = 1'b1;
        base_adr = base;
        count    = cnt;
        @(posedge clk);
        #1;
        start = 1'b0;
        k = 1;
        @(negedge clk);
        if (cnt != 0) begin
            check("busy_n1", {31'h0, busy}, 32'h1);
            check("memop_n1", {31'h0, dbg_mem_op}, 32'h1);
            check("adr_n1", dbg_adr, {base[31:2], 2'b00});
        end
        while (!done && k < 400) begin
            if (extra_start && k == 2) begin
                start    = 1'b1;
                base_adr = 32'h0000_3000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_reached", {31'h0, done}, 32'h1);
        check("busy_in_done", {31'h0, busy}, 32'h0);
        lat = k;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        n_reset  = 1'b0;
        start    = 1'b0;
        base_adr = '0;
        count    = '0;
        abort    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_memop", {31'h0, dbg_mem_op}, 32'h0);
        check("rst_wren", {28'h0, dbg_wren}, 32'h0);
        check("rst_adr", dbg_adr, 32'h0);
        check("rst_txd", {24'h0, tx_data}, 32'h0);
        check("rst_txv", {31'h0, tx_valid}, 32'h0);
        n_reset = 1'b1;

        run_xfer(32'h0002_0000, 16'd2, 0, lat);
        check("lat_cnt2", lat, 13);
        check("q_empty_cnt2", exp_q.size(), 0);
        check("adr_log_n", adr_log.size(), 2);
        if (adr_log.size() == 2) check("adr_w1", adr_log[1], 32'h0002_0004);

        run_xfer(32'h0002_0000, 16'd0, 0, lat);
        @(posedge clk);
        check("lat_cnt0", lat, 1);
        check("cnt0_no_memop", {31'h0, memop_seen}, 32'h0);
        check("cnt0_no_txv", {31'h0, txv_seen}, 32'h0);

        run_xfer(32'h0002_0003, 16'd1, 0, lat);
        check("lat_cnt1", lat, 7);
        check("q_empty_cnt1", exp_q.size(), 0);

        run_xfer(32'hFFFF_FFFC, 16'd2, 0, lat);
        check("lat_wrap", lat, 13);
        check("q_empty_wrap", exp_q.size(), 0);
        if (adr_log.size() == 2) check("adr_wrap", adr_log[1], 32'h0);
        else check("adr_wrap_n", adr_log.size(), 2);

        ready_mode = 1;
        run_xfer(32'h0002_0000, 16'd3, 0, lat);
        ready_mode = 0;
        check("q_empty_stall", exp_q.size(), 0);

        run_xfer(32'h0002_0000, 16'd1, 1, lat);
        check("lat_restart", lat, 7);
        check("q_empty_restart", exp_q.size(), 0);
        check("restart_adr_n", adr_log.size(), 1);

        // Abort while the second word's first byte is stalled.
        done_seen = 0;
        push_word(mem_word(32'h0002_0000));
        @(posedge clk);
        #1;
        start    = 1'b1;
        base_adr = 32'h0002_0000;
        count    = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        ready_mode = 2;
        @(posedge clk);
        #2;
        abort = 1'b1;
        @(negedge clk);
        check("abort_in_send", {31'h0, tx_valid}, 32'h1);
        @(posedge clk);
        #2;
        abort = 1'b0;
        @(negedge clk);
        check("abort_txv", {31'h0, tx_valid}, 32'h0);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_memop", {31'h0, dbg_mem_op}, 32'h0);
        repeat (3) @(posedge clk);
        check("abort_no_done", {31'h0, done_seen}, 32'h0);
        check("q_empty_abort", exp_q.size(), 0);
        ready_mode = 0;

        run_xfer(32'h0002_0004, 16'd1, 0, lat);
        check("lat_after_abort", lat, 7);
        check("q_empty_after_abort", exp_q.size(), 0);

        // Async reset while in WAIT.
        done_seen = 0;
        push_word(mem_word(32'h0002_0000));
        @(posedge clk);
        #1;
        start    = 1'b1;
        base_adr = 32'h0002_0000;
        count    = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wait_memop", {31'h0, dbg_mem_op}, 32'h1);
        #2;
        n_reset = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 32'h0);
        check("arst_memop", {31'h0, dbg_mem_op}, 32'h0);
        check("arst_adr", dbg_adr, 32'h0);
        check("arst_txv", {31'h0, tx_valid}, 32'h0);
        check("arst_done", {31'h0, done}, 32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        repeat (4) @(posedge clk);
        check("arst_no_done", {31'h0, done_seen}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
